// File: rtl/age_issue_pkg.sv
// Shared helpers for the age-ordered issue queue: index width and the
// packing of the upper-triangular age matrix into a flat vector.
package age_issue_pkg;

   function automatic int idx_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Only pairs i<j are stored; the lower triangle is the inverse.
   function automatic int age_bits(input int depth);
      return (depth * (depth - 1)) / 2;
   endfunction

   // Flat position of stored pair (i,j), i<j, row-major over the upper triangle.
   function automatic int tri_idx(input int i, input int j, input int depth);
      return i * depth - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

endpackage

// File: rtl/age_oldest_sel.sv
// Picks the oldest candidate: the one that is older than every other candidate.
module age_oldest_sel
   import age_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]       cand,
   input  logic [DEPTH*DEPTH-1:0] age_mat,
   output logic [DEPTH-1:0]       oldest,
   output logic                   any
);

   // a candidate drops out as soon as any other candidate is older than it
   always_comb begin
      oldest = '0;
      for (int i = 0; i < DEPTH; i++) begin
         oldest[i] = cand[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (cand[j] && !age_mat[i*DEPTH+j]) oldest[i] = 1'b0;
         end
      end
   end

   assign any = |cand;

endmodule

// File: rtl/age_issue_queue.sv
// Age-ordered issue buffer: allocates into the lowest free slot, issues the
// oldest ready entry, and holds a presented entry fixed while stalled.
module age_issue_queue
   import age_issue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8,
   parameter int IDX_W  = idx_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_rdy,
   output logic [IDX_W-1:0]  in_idx,
   input  logic              wake_valid,
   input  logic [IDX_W-1:0]  wake_idx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic [IDX_W:0]    count,
   output logic              full,
   output logic              empty
);

   typedef struct packed {
      logic              vld;
      logic              rdy;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam int AGE_W = age_bits(DEPTH);

   entry_t [DEPTH-1:0]     ent_q, ent_d;
   logic [AGE_W-1:0]       age_q, age_d;
   logic                   locked_q, locked_d;
   logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;

   logic [DEPTH-1:0]       vld_vec, cand, oldest;
   logic                   any_cand, free_found;
   logic [DEPTH*DEPTH-1:0] age_mat;
   logic [IDX_W-1:0]       sel_idx, pres_idx, free_idx;
   logic [IDX_W:0]         occ;
   logic                   alloc_fire, issue_fire;

   // occupancy, candidate set and lowest free slot, all from registered state
   always_comb begin
      vld_vec    = '0;
      cand       = '0;
      occ        = '0;
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         vld_vec[i] = ent_q[i].vld;
         cand[i]    = ent_q[i].vld & ent_q[i].rdy;
         occ        = occ + {{IDX_W{1'b0}}, ent_q[i].vld};
         if (!ent_q[i].vld && !free_found) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // expand the stored upper triangle into the full matrix, diagonal set
   always_comb begin
      age_mat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (i == j)     age_mat[i*DEPTH+j] = 1'b1;
            else if (i < j) age_mat[i*DEPTH+j] = age_q[tri_idx(i, j, DEPTH)];
            else            age_mat[i*DEPTH+j] = ~age_q[tri_idx(j, i, DEPTH)];
         end
      end
   end

   age_oldest_sel #(.DEPTH(DEPTH)) u_sel (
      .cand    (cand),
      .age_mat (age_mat),
      .oldest  (oldest),
      .any     (any_cand)
   );

   // one-hot oldest to index
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oldest[i]) sel_idx = sel_idx | IDX_W'(i);
      end
   end

   assign pres_idx  = locked_q ? lock_idx_q : sel_idx;
   assign out_valid = locked_q | any_cand;
   assign out_idx   = out_valid ? pres_idx : '0;
   assign full      = &vld_vec;
   assign empty     = ~|vld_vec;
   assign in_ready  = ~full;
   assign in_idx    = free_idx;
   assign count     = occ;

   assign alloc_fire = in_valid & in_ready;
   assign issue_fire = out_valid & out_ready;

   // payload mux, zero while nothing is presented
   always_comb begin
      out_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (out_valid && out_idx == IDX_W'(i)) out_data = ent_q[i].data;
      end
   end

   // wake, allocate, issue and lock updates; issue clears last so it wins
   always_comb begin
      ent_d      = ent_q;
      age_d      = age_q;
      locked_d   = locked_q;
      lock_idx_d = lock_idx_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wake_valid && wake_idx == IDX_W'(i) && ent_q[i].vld) ent_d[i].rdy = 1'b1;
         if (alloc_fire && free_idx == IDX_W'(i)) begin
            ent_d[i].vld  = 1'b1;
            ent_d[i].rdy  = in_rdy;
            ent_d[i].data = in_data;
         end
         if (issue_fire && out_idx == IDX_W'(i)) begin
            ent_d[i].vld = 1'b0;
            ent_d[i].rdy = 1'b0;
         end
      end
      // newly allocated slot becomes younger than every other slot
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = i + 1; j < DEPTH; j++) begin
            if (alloc_fire && free_idx == IDX_W'(j)) age_d[tri_idx(i, j, DEPTH)] = 1'b1;
            if (alloc_fire && free_idx == IDX_W'(i)) age_d[tri_idx(i, j, DEPTH)] = 1'b0;
         end
      end
      if (issue_fire) begin
         locked_d = 1'b0;
      end else if (out_valid) begin
         locked_d   = 1'b1;
         lock_idx_d = pres_idx;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q      <= '0;
         age_q      <= '0;
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ent_q      <= ent_d;
         age_q      <= age_d;
         locked_q   <= locked_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue (DEPTH=4, DATA_W=8).
module tb_age_issue_queue;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_rdy, wake_valid, out_ready;
   logic [7:0] in_data;
   logic [1:0] wake_idx;
   logic       in_ready, out_valid, full, empty;
   logic [1:0] in_idx, out_idx;
   logic [7:0] out_data;
   logic [2:0] count;

   int n_cmp = 0;
   int n_err = 0;

   age_issue_queue #(.DEPTH(4), .DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_rdy     (in_rdy),
      .in_idx     (in_idx),
      .wake_valid (wake_valid),
      .wake_idx   (wake_idx),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_rdy = 1'b0; in_data = 8'h00;
      wake_valid = 1'b0; wake_idx = 2'd0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", full); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_cmp++; if (out_idx !== 2'd0 || out_data !== 8'h00) begin n_err++; $display("FAIL reset_out: got idx %0d data %h exp 0 00", out_idx, out_data); end
   endtask

   // A, B, C back to back with the consumer always ready; slot 0 frees in
   // time for C, so C lands in slot 0 again
   task automatic test_back_to_back();
      out_ready = 1'b1; in_valid = 1'b1; in_rdy = 1'b1; in_data = 8'hA1;
      n_cmp++; if (in_idx !== 2'd0) begin n_err++; $display("FAIL b2b_in_idx_a: got %0d exp 0", in_idx); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 8'hA1) begin n_err++; $display("FAIL b2b_issue_a: got v%b idx %0d data %h exp v1 0 a1", out_valid, out_idx, out_data); end
      in_data = 8'hB2;
      n_cmp++; if (in_idx !== 2'd1) begin n_err++; $display("FAIL b2b_in_idx_b: got %0d exp 1", in_idx); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 8'hB2) begin n_err++; $display("FAIL b2b_issue_b: got v%b idx %0d data %h exp v1 1 b2", out_valid, out_idx, out_data); end
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count_b: got %0d exp 1", count); end
      in_data = 8'hC3;
      n_cmp++; if (in_idx !== 2'd0) begin n_err++; $display("FAIL b2b_in_idx_c: got %0d exp 0", in_idx); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 8'hC3) begin n_err++; $display("FAIL b2b_issue_c: got v%b idx %0d data %h exp v1 0 c3", out_valid, out_idx, out_data); end
      tick();
      n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got cnt %0d empty %b v%b exp 0 1 0", count, empty, out_valid); end
   endtask

   // older A not ready, younger B woken first: B issues before A
   task automatic test_wake_order();
      out_ready = 1'b1; in_valid = 1'b1; in_rdy = 1'b0; in_data = 8'h0A;
      tick();
      in_data = 8'h0B;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || count !== 3'd2) begin n_err++; $display("FAIL wake_idle: got v%b cnt %0d exp v0 2", out_valid, count); end
      wake_valid = 1'b1; wake_idx = 2'd1;
      tick();
      wake_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 8'h0B) begin n_err++; $display("FAIL wake_b_first: got v%b idx %0d data %h exp v1 1 0b", out_valid, out_idx, out_data); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || count !== 3'd1) begin n_err++; $display("FAIL wake_a_waiting: got v%b cnt %0d exp v0 1", out_valid, count); end
      wake_valid = 1'b1; wake_idx = 2'd0;
      tick();
      wake_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 8'h0A) begin n_err++; $display("FAIL wake_a_second: got v%b idx %0d data %h exp v1 0 0a", out_valid, out_idx, out_data); end
      tick();
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wake_drain: got empty %b exp 1", empty); end
   endtask

   // B presented and stalled; older A wakes mid-stall but B must stay put
   task automatic test_stall_lock();
      out_ready = 1'b0; in_valid = 1'b1; in_rdy = 1'b0; in_data = 8'h1A;
      tick();
      in_data = 8'h1B;
      tick();
      in_valid = 1'b0;
      wake_valid = 1'b1; wake_idx = 2'd1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd1) begin n_err++; $display("FAIL lock_present: got v%b idx %0d exp v1 1", out_valid, out_idx); end
      wake_idx = 2'd0;
      tick();
      wake_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 8'h1B) begin n_err++; $display("FAIL lock_stall1: got v%b idx %0d data %h exp v1 1 1b", out_valid, out_idx, out_data); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 8'h1B) begin n_err++; $display("FAIL lock_stall2: got v%b idx %0d data %h exp v1 1 1b", out_valid, out_idx, out_data); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 8'h1A) begin n_err++; $display("FAIL lock_then_a: got v%b idx %0d data %h exp v1 0 1a", out_valid, out_idx, out_data); end
      tick();
      n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL lock_drain: got empty %b v%b exp 1 0", empty, out_valid); end
   endtask

   // fill, issue slot 2 while allocation is pending, reuse slot 2 next cycle
   task automatic test_full_reuse();
      out_ready = 1'b0; in_valid = 1'b1; in_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_data = 8'h10 + 8'(k);
         tick();
      end
      n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin n_err++; $display("FAIL full_flags: got full %b in_ready %b cnt %0d exp 1 0 4", full, in_ready, count); end
      in_data = 8'h55; wake_valid = 1'b1; wake_idx = 2'd2;
      tick();
      wake_valid = 1'b0;
      n_cmp++; if (count !== 3'd4 || out_idx !== 2'd2 || out_data !== 8'h12) begin n_err++; $display("FAIL full_no_alloc: got cnt %0d idx %0d data %h exp 4 2 12", count, out_idx, out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (count !== 3'd3 || in_idx !== 2'd2 || in_ready !== 1'b1) begin n_err++; $display("FAIL full_freed: got cnt %0d in_idx %0d in_ready %b exp 3 2 1", count, in_idx, in_ready); end
      in_rdy = 1'b1; wake_valid = 1'b1; wake_idx = 2'd3;
      tick();
      in_valid = 1'b0; in_rdy = 1'b0; wake_valid = 1'b0;
      n_cmp++; if (count !== 3'd4 || out_idx !== 2'd3 || out_data !== 8'h13) begin n_err++; $display("FAIL full_reuse_young: got cnt %0d idx %0d data %h exp 4 3 13", count, out_idx, out_data); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_idx !== 2'd2 || out_data !== 8'h55) begin n_err++; $display("FAIL full_reuse_issue: got idx %0d data %h exp 2 55", out_idx, out_data); end
      tick();
      n_cmp++; if (count !== 3'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL full_left: got cnt %0d v%b exp 2 0", count, out_valid); end
   endtask

   // slots 0,1 hold 10,11 not ready: allocate and issue together, then wakes to empty slots
   task automatic test_same_cycle();
      out_ready = 1'b1; wake_valid = 1'b1; wake_idx = 2'd0;
      tick();
      wake_valid = 1'b0;
      n_cmp++; if (out_idx !== 2'd0 || out_data !== 8'h10 || count !== 3'd2) begin n_err++; $display("FAIL same_present: got idx %0d data %h cnt %0d exp 0 10 2", out_idx, out_data, count); end
      in_valid = 1'b1; in_rdy = 1'b0; in_data = 8'h66;
      n_cmp++; if (in_idx !== 2'd2) begin n_err++; $display("FAIL same_in_idx: got %0d exp 2", in_idx); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (count !== 3'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL same_count: got cnt %0d v%b exp 2 0", count, out_valid); end
      wake_valid = 1'b1; wake_idx = 2'd3;
      tick();
      n_cmp++; if (count !== 3'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL wake_empty: got cnt %0d v%b exp 2 0", count, out_valid); end
      wake_idx = 2'd0; in_valid = 1'b1; in_rdy = 1'b0; in_data = 8'h77;
      tick();
      wake_valid = 1'b0; in_valid = 1'b0;
      n_cmp++; if (count !== 3'd3 || out_valid !== 1'b0) begin n_err++; $display("FAIL wake_alloc_same: got cnt %0d v%b exp 3 0", count, out_valid); end
   endtask

   // three entries queued with a locked presentation, then reset
   task automatic test_reset_mid();
      out_ready = 1'b0; wake_valid = 1'b1; wake_idx = 2'd1;
      tick();
      wake_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || count !== 3'd3) begin n_err++; $display("FAIL rstmid_locked: got v%b idx %0d cnt %0d exp v1 1 3", out_valid, out_idx, count); end
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL rstmid_clear: got empty %b v%b cnt %0d exp 1 0 0", empty, out_valid, count); end
      in_valid = 1'b1; in_rdy = 1'b1; in_data = 8'h99;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 8'h99) begin n_err++; $display("FAIL rstmid_after: got v%b idx %0d data %h exp v1 0 99", out_valid, out_idx, out_data); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_wake_order();
      test_stall_lock();
      test_full_reuse();
      test_same_cycle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
